// File: rtl/cordic_angle_reducer.sv
// cordic_angle_reducer
// Front end for the CORDIC sine/cosine core. It folds an unsigned Q3.29
// angle into [0, pi/2) by repeated subtraction of pi/2 and derives the
// region code and the result sign. It then runs the begin/ready/ack
// handshake with the CORDIC FSM on behalf of the requester.
module cordic_angle_reducer #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   HALF_PI = 32'h3243F6A9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] angle_in,
  input  logic         op_in,
  input  logic         ack_in,
  input  logic         ready_CORDIC,
  output logic         beg_FSM_CORDIC,
  output logic         ACK_FSM_CORDIC,
  output logic [W-1:0] angle_red,
  output logic [1:0]   shift_region_flag,
  output logic         operation,
  output logic         sign_neg,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t       state_q;
  logic [W-1:0] res_q;
  logic [2:0]   k_q;
  logic         op_q;
  logic [W-1:0] angle_red_q;
  logic [1:0]   region_q;
  logic         sign_neg_q;
  logic         busy_q;

  // Candidate residual after one more quarter-turn removal
  logic [W-1:0] res_sub_d;
  // Quadrant is the low two bits of the subtraction count
  logic [1:0]   quad_d;
  // Gray-style region code: q0->00, q1->01, q2->11, q3->10
  logic [1:0]   region_d;
  logic         sign_neg_d;

  assign res_sub_d  = res_q - HALF_PI;
  assign quad_d     = k_q[1:0];
  assign region_d   = {quad_d[1], quad_d[1] ^ quad_d[0]};
  // Cosine is negative in q1/q2, sine in q2/q3
  assign sign_neg_d = op_q ? quad_d[1] : (quad_d[1] ^ quad_d[0]);

  // Control FSM: reduction loop, CORDIC handshake and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      res_q       <= '0;
      k_q         <= '0;
      op_q        <= 1'b0;
      angle_red_q <= '0;
      region_q    <= 2'b00;
      sign_neg_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            res_q   <= angle_in;
            op_q    <= op_in;
            k_q     <= '0;
            state_q <= S_REDUCE;
            busy_q  <= 1'b1;
          end
        end
        S_REDUCE: begin
          // Compare and subtract are unsigned; the subtract only fires
          // when res_q >= HALF_PI, so it can never wrap.
          if (res_q >= HALF_PI) begin
            res_q <= res_sub_d;
            k_q   <= k_q + 3'd1;
          end else begin
            angle_red_q <= res_q;
            region_q    <= region_d;
            sign_neg_q  <= sign_neg_d;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // ack_in is deliberately ignored here; only DONE consumes it
          if (ready_CORDIC) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack_in) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign beg_FSM_CORDIC    = (state_q == S_ISSUE);
  assign done              = (state_q == S_DONE);
  // Same-cycle acknowledge to the CORDIC FSM while the requester acks
  assign ACK_FSM_CORDIC    = (state_q == S_DONE) && ack_in;
  assign angle_red         = angle_red_q;
  assign shift_region_flag = region_q;
  assign operation         = op_q;
  assign sign_neg          = sign_neg_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// tb_cordic_angle_reducer
// Directed vectors for the angle reducer with hand-computed residuals,
// region codes, signs and start-to-begin latencies, plus handshake and
// mid-operation reset scenarios.
module tb_cordic_angle_reducer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] angle_in;
  logic        op_in;
  logic        ack_in;
  logic        ready_CORDIC;
  logic        beg_FSM_CORDIC;
  logic        ACK_FSM_CORDIC;
  logic [31:0] angle_red;
  logic [1:0]  shift_region_flag;
  logic        operation;
  logic        sign_neg;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  cordic_angle_reducer #(
    .W       (32),
    .HALF_PI (32'h3243F6A9)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .angle_in          (angle_in),
    .op_in             (op_in),
    .ack_in            (ack_in),
    .ready_CORDIC      (ready_CORDIC),
    .beg_FSM_CORDIC    (beg_FSM_CORDIC),
    .ACK_FSM_CORDIC    (ACK_FSM_CORDIC),
    .angle_red         (angle_red),
    .shift_region_flag (shift_region_flag),
    .operation         (operation),
    .sign_neg          (sign_neg),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start and count edges (the sampling edge included) until beg pulses
  task automatic launch(input logic [31:0] ang, input logic op, output int lat);
    angle_in = ang;
    op_in    = op;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    while (!beg_FSM_CORDIC && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Full transaction with immediate ready and ack
  task automatic run_txn(input string tag, input logic [31:0] ang, input logic op,
                         input logic [31:0] exp_red, input logic [1:0] exp_reg,
                         input logic exp_sign, input int exp_lat);
    int lat;
    launch(ang, op, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_red"}, angle_red, exp_red);
    chk({tag, "_reg"}, {30'd0, shift_region_flag}, {30'd0, exp_reg});
    chk({tag, "_sign"}, {31'd0, sign_neg}, {31'd0, exp_sign});
    chk({tag, "_op"}, {31'd0, operation}, {31'd0, op});
    step();
    chk({tag, "_beg_1cyc"}, {31'd0, beg_FSM_CORDIC}, 32'd0);
    ready_CORDIC = 1'b1;
    step();
    ready_CORDIC = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    ack_in = 1'b1;
    #1;
    chk({tag, "_ackfsm"}, {31'd0, ACK_FSM_CORDIC}, 32'd1);
    step();
    ack_in = 1'b0;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    $display("txn %s angle=%h op=%0d red=%h reg=%b neg=%0d lat=%0d",
             tag, ang, op, angle_red, shift_region_flag, sign_neg, lat);
  endtask

  initial begin
    int lat;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    start        = 1'b0;
    angle_in     = '0;
    op_in        = 1'b0;
    ack_in       = 1'b0;
    ready_CORDIC = 1'b0;
    step();
    step();
    chk("rst_red", angle_red, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_beg", {31'd0, beg_FSM_CORDIC}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();

    // Directed vectors: residual, region, sign, latency = 2 + subtract count
    run_txn("zero_cos",  32'h00000000, 1'b0, 32'h00000000, 2'b00, 1'b0, 2);
    run_txn("two_cos",   32'h40000000, 1'b0, 32'h0DBC0957, 2'b01, 1'b1, 3);
    run_txn("five_sin",  32'hA0000000, 1'b1, 32'h09341C05, 2'b10, 1'b1, 5);
    run_txn("hpi_cos",   32'h3243F6A9, 1'b0, 32'h00000000, 2'b01, 1'b1, 3);
    run_txn("max_sin",   32'hFFFFFFFF, 1'b1, 32'h04AC2EB2, 2'b01, 1'b0, 7);
    run_txn("pi_sin",    32'h6487ED52, 1'b1, 32'h00000000, 2'b11, 1'b1, 4);
    run_txn("small_sin", 32'h10000000, 1'b1, 32'h10000000, 2'b00, 1'b0, 2);

    // Handshake: long ready delay, ignored start, delayed ack
    launch(32'h40000000, 1'b1, lat);
    chk("hs_lat", lat, 3);
    step();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        angle_in = 32'h00000000;
        op_in    = 1'b0;
        start    = 1'b1;
      end
      if (i == 6) start = 1'b0;
      if (i == 10) ack_in = 1'b1;
      if (i == 11) ack_in = 1'b0;
      step();
    end
    chk("hs_wait_done", {31'd0, done}, 32'd0);
    chk("hs_wait_busy", {31'd0, busy}, 32'd1);
    chk("hs_ign_red", angle_red, 32'h0DBC0957);
    chk("hs_ign_op", {31'd0, operation}, 32'd1);
    ready_CORDIC = 1'b1;
    step();
    ready_CORDIC = 1'b0;
    chk("hs_done_rise", {31'd0, done}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hs_done_hold", {31'd0, done}, 32'd1);
      chk("hs_ack_low", {31'd0, ACK_FSM_CORDIC}, 32'd0);
    end
    ack_in = 1'b1;
    #1;
    chk("hs_ack_pulse", {31'd0, ACK_FSM_CORDIC}, 32'd1);
    step();
    ack_in = 1'b0;
    chk("hs_ack_gone", {31'd0, ACK_FSM_CORDIC}, 32'd0);
    chk("hs_idle", {31'd0, busy}, 32'd0);
    $display("txn handshake red=%h reg=%b neg=%0d", angle_red, shift_region_flag, sign_neg);

    // Reset during WAIT clears every output at once
    launch(32'hA0000000, 1'b1, lat);
    chk("mr_lat", lat, 5);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("mr_red", angle_red, 32'd0);
    chk("mr_reg", {30'd0, shift_region_flag}, 32'd0);
    chk("mr_sign", {31'd0, sign_neg}, 32'd0);
    chk("mr_op", {31'd0, operation}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    step();
    reset = 1'b0;
    step();
    $display("txn midreset busy=%0d red=%h", busy, angle_red);
    run_txn("post_rst", 32'h40000000, 1'b0, 32'h0DBC0957, 2'b01, 1'b1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_angle_reducer.md
# cordic_angle_reducer

Front-end stage for the CORDIC sine/cosine core. It accepts an unsigned fixed-point angle and reduces it iteratively to a residual in [0, π/2), and derives the 2-bit region code and the result sign. It then drives the CORDIC controller's start/ack handshake (`beg_FSM_CORDIC`, `ready_CORDIC`, `ACK_FSM_CORDIC`) on behalf of the upstream requester. It sits between the requesting datapath and the CORDIC core/FSM.

## Interface
- `W`, 32: angle width, unsigned Q3.(W-3).
- `HALF_PI`, 32'h3243F6A9: π/2 in Q3.29.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `angle_in`  in  W  angle, range [0, 8) rad.
- `op_in`  in  1  0 = cosine, 1 = sine.
- `ack_in`  in  1  requester has consumed the result.
- `ready_CORDIC`  in  1  CORDIC FSM result-ready flag.
- `beg_FSM_CORDIC`  out  1  one-cycle start pulse to the CORDIC FSM.
- `ACK_FSM_CORDIC`  out  1  acknowledge to the CORDIC FSM.
- `angle_red`  out  W  reduced angle, in [0, HALF_PI).
- `shift_region_flag`  out  2  region code to the CORDIC FSM.
- `operation`  out  1  latched `op_in`.
- `sign_neg`  out  1  final result must be negated.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  result valid; held until `ack_in`.

## Operation
- States: IDLE, REDUCE, ISSUE, WAIT, DONE.
- **IDLE:**
  - When `start` is high, latch `angle_in` into `res`, latch `op_in`, clear the 3-bit quadrant counter `k`, and go to REDUCE.
  - `start` is ignored in every other state.
- **REDUCE**, one step per cycle:
  - If `res >= HALF_PI`: `res <= res - HALF_PI` and `k <= k + 1`.
  - Otherwise go to ISSUE.
  - At most 5 subtract steps occur, because 8/(π/2) < 5.1.
  - Quadrant q = k mod 4.
- **Region encoding:**
  - q0 → 00, q1 → 01, q2 → 11, q3 → 10.
  - With this encoding, cosine in regions 01/10 selects the CORDIC Y output and otherwise selects X. Sine is the complement.
- **sign_neg:**
  - Cosine: 1 for q1 and q2.
  - Sine: 1 for q2 and q3.
- **Output registers:** `angle_red`, `shift_region_flag` and `sign_neg` are registered on the REDUCE → ISSUE transition. They hold until the next accepted `start`.
- **ISSUE:** `beg_FSM_CORDIC = 1` for exactly one cycle, then go to WAIT.
- **WAIT:** stay until `ready_CORDIC = 1`, then go to DONE.
- **DONE:**
  - `done = 1`.
  - When `ack_in = 1`, assert `ACK_FSM_CORDIC = 1` combinationally in that same cycle and go to IDLE.
- **Arithmetic:**
  - Comparison and subtraction are unsigned, W bits wide.
  - No wrap is possible because the subtract only occurs when `res >= HALF_PI`.
- **Exact boundary:** `angle_in == HALF_PI` gives residual 0, q1.

## Timing
- **Reset:** state = IDLE and all outputs are 0, including `angle_red`, `shift_region_flag`, `operation` and `sign_neg`.
- **Reset mid-operation:** IDLE is entered immediately and any handshake in progress is abandoned. Because `ACK_FSM_CORDIC` is never issued, the CORDIC FSM must also be reset.
- **Latency, `start` to `beg_FSM_CORDIC`:** 2 + n cycles, where n ∈ [0, 5] is the number of subtract steps.
  - `start` is sampled at edge 0.
  - REDUCE occupies n + 1 cycles.
  - ISSUE follows.
- **Output stability:** `angle_red`, `shift_region_flag` and `operation` are stable from ISSUE through DONE, as the CORDIC FSM requires.
- **`done`:** rises one cycle after `ready_CORDIC` is sampled high.
- **Simultaneous `ready_CORDIC` and `ack_in` in WAIT:** `ack_in` is ignored; only DONE acts on `ack_in`.
- **Back-to-back:** after the acknowledging cycle, the next `start` is accepted one cycle later, in IDLE.
- **`busy`:** a registered state decode.
- **`beg_FSM_CORDIC`, `ACK_FSM_CORDIC`, `done`:** Moore/Mealy decodes as described in Operation, with no extra delay.

## Test plan
- **Zero angle:** `angle_in` = 0, cosine → `angle_red` = 0, region 00, `sign_neg` = 0; `beg_FSM_CORDIC` 2 cycles after `start`.
- **2.0 rad:** `angle_in` = 32'h40000000, cosine → `angle_red` = 32'h0DBC0957, region 01, `sign_neg` = 1.
- **5.0 rad:** `angle_in` = 32'hA0000000, sine → `angle_red` = 32'h09341C05, region 10, `sign_neg` = 1; `beg_FSM_CORDIC` 5 cycles after `start`.
- **Boundaries:**
  - `angle_in` = 32'h3243F6A9 → residual 0, region 01.
  - `angle_in` = 32'hFFFFFFFF → 5 subtract steps, q1, region 01.
- **Handshake:**
  - Hold `ready_CORDIC` low for 20 cycles → WAIT holds, `done` = 0.
  - Raise `ready_CORDIC` → `done` = 1 the next cycle.
  - Delay `ack_in` by 7 cycles → `done` holds; `ACK_FSM_CORDIC` pulses for one cycle coincident with `ack_in`.
  - A `start` pulse issued while busy is ignored.
- **Reset mid-operation:** assert `reset` during WAIT → all outputs 0 immediately; a following `start` runs a clean transaction.
